// File: rtl/rr_mux_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_mux_arbiter_pkg
//  Description : Shared definitions for the round-robin mux arbiter:
//                FSM state encoding, default parameter values and a helper
//                that sizes the beat counter.
//  Revision    : 1.0  initial release
// ============================================================================
package rr_mux_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int unsigned DEF_N     = 4;
    localparam int unsigned DEF_SELW  = 2;
    localparam int unsigned DEF_W     = 8;
    localparam int unsigned DEF_BURST = 4;

    // Beat counter must count 0..BURST-1; a 1-bit counter is kept even for BURST=1.
    function automatic int unsigned cnt_width(input int unsigned burst);
        return (burst > 1) ? $clog2(burst) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_mux_arbiter_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin pick. Finds the first requester
//                after last_owner (wrapping modulo N).
//  Ports       : req[N]          request vector
//                last_owner      index of the previous owner
//                found           at least one request is pending
//                idx             index of the winning requester
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick
    import rr_mux_arbiter_pkg::*;
#(
    parameter int unsigned N    = DEF_N,
    parameter int unsigned SELW = DEF_SELW
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] last_owner,
    output logic            found,
    output logic [SELW-1:0] idx
);

    localparam logic [SELW:0] c_N = (SELW+1)'(N);

    logic [SELW:0]   w_start;
    logic [2*N-1:0]  w_dbl_shift;
    logic [N-1:0]    w_rot;
    logic [SELW-1:0] w_off;
    logic [SELW:0]   w_sum;

    // Search begins one past the previous owner; N need not be a power of two,
    // so the wrap is explicit rather than relying on overflow.
    assign w_start     = ({1'b0, last_owner} == c_N - 1'b1) ? '0 : {1'b0, last_owner} + 1'b1;

    // Rotate: doubling the vector turns a circular shift into a plain shift.
    assign w_dbl_shift = {req, req} >> w_start;
    assign w_rot       = w_dbl_shift[N-1:0];

    // Priority-encode the rotated vector (lowest set bit wins).
    always_comb begin
        w_off = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = SELW'(i);
            end
        end
    end

    // Rotate back to an absolute requester index.
    assign w_sum = w_start + {1'b0, w_off};
    assign idx   = (w_sum >= c_N) ? SELW'(w_sum - c_N) : SELW'(w_sum);
    assign found = |req;

endmodule
`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_mux_arbiter
//  Description : Round-robin arbiter sharing one valid/ready output channel
//                among N requesters. Holds a grant for up to BURST beats and
//                drives the select of a W-bit N:1 data mux.
//  Ports       : clk, rst_n      clock, synchronous active-low reset
//                req[N]          per-requester request (held while data)
//                data_in[N*W]    packed data, requester i at [i*W +: W]
//                gnt[N]          registered one-hot grant
//                sel[SELW]       registered owner index (mux select)
//                out_valid       busy & req[sel]
//                out_data[W]     combinational mux of data_in by sel
//                out_ready       consumer accept
//                busy            grant active
//  Revision    : 1.0  initial release
// ============================================================================
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned SELW  = DEF_SELW,
    parameter int unsigned W     = DEF_W,
    parameter int unsigned BURST = DEF_BURST
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  data_in,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] sel,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    input  logic            out_ready,
    output logic            busy
);

    localparam int unsigned   CW     = cnt_width(BURST);
    localparam logic [CW-1:0] c_LAST = CW'(BURST - 1);

    state_t          r_state, w_state_nxt;
    logic [N-1:0]    r_gnt, w_gnt_nxt;
    logic [SELW-1:0] r_sel, w_sel_nxt;
    logic [SELW-1:0] r_last, w_last_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;

    logic            w_found;
    logic [SELW-1:0] w_idx;
    logic            w_owner_req;
    logic            w_beat;
    logic [W-1:0]    w_slice [N];

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_pick (
        .req        (req),
        .last_owner (r_last),
        .found      (w_found),
        .idx        (w_idx)
    );

    assign w_owner_req = req[r_sel];
    assign busy        = (r_state == ST_BUSY);
    assign out_valid   = busy & w_owner_req;
    assign w_beat      = out_valid & out_ready;
    assign gnt         = r_gnt;
    assign sel         = r_sel;

    genvar gi;
    generate
        for (gi = 0; gi < int'(N); gi++) begin : g_slice
            assign w_slice[gi] = data_in[gi*W +: W];
        end
    endgenerate

    assign out_data = w_slice[r_sel];

    // Next-state logic. sel/gnt only change on the IDLE->BUSY transition, so
    // the mux select is stable for the whole burst.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt = '0;
                if (w_found) begin
                    w_state_nxt = ST_BUSY;
                    w_sel_nxt   = w_idx;
                    w_gnt_nxt   = N'(1) << w_idx;
                    w_cnt_nxt   = '0;
                end
            end
            ST_BUSY: begin
                // Owner withdrawal and the final beat both release; sel is
                // kept so last_owner and the mux stay consistent.
                if (!w_owner_req || (w_beat && (r_cnt == c_LAST))) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                    w_last_nxt  = r_sel;
                    w_cnt_nxt   = '0;
                end else if (w_beat) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_last  <= SELW'(N - 1);
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule
`default_nettype wire
